// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the extended UART receiver.
package uart_pkg;
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;
  typedef struct packed {
    logic       frame;
    logic       parity;
    logic [7:0] data;
  } rx_entry_t;
  localparam int ENTRY_W = $bits(rx_entry_t);
  localparam logic [15:0] MIN_PERIOD = 16'd4;
  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; a write into a full FIFO is accepted only alongside a read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [AW:0]      count,
  output logic             drop
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, do_rd, do_wr;
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_rd = rd_en && valid;
  assign do_wr = wr_en && (!full || do_rd);
  assign drop = wr_en && full && !do_rd;
  assign rd_data = valid ? mem[rp] : '0;
  always_ff @(posedge clk) if (do_wr) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: configurable UART receiver with majority-voted sampling and an error-tagged receive FIFO.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_bit_period_i,
  input  logic [15:0]                   bit_period_i,
  input  logic [1:0]                    cfg_data_bits_i,
  input  logic [1:0]                    cfg_parity_i,
  input  logic                          cfg_stop2_i,
  input  logic                          uart_rx_en,
  input  logic                          uart_rxd,
  input  logic                          rd_en_i,
  output logic                          rd_valid_o,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_parity_err_o,
  output logic                          rd_frame_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overrun_o,
  input  logic                          clr_overrun_i
);
  localparam logic [15:0] RST_PERIOD = clamp_period(16'(CLK_FREQ / BAUD_RATE));
  state_e state, state_n;
  parity_e par, par_n;
  logic s1, s2, sp, v0, v1, maj, fall, smp, bit_end, push, drop;
  logic [15:0] period_q, per, per_n, cnt, cnt_n, half;
  logic [2:0] idx, idx_n;
  logic [1:0] db, db_n;
  logic st2, st2_n, perr, perr_n, ferr, ferr_n;
  logic [7:0] data, data_n;
  rx_entry_t wr_entry, head;
  assign fall = sp & ~s2;
  assign half = per >> 1;
  assign smp = cnt == half + 16'd1;
  assign bit_end = cnt == per - 16'd1;
  // Vote over the taps at half-1 and half plus the live line at half+1.
  assign maj = (v0 & v1) | (v0 & s2) | (v1 & s2);
  assign wr_entry = '{frame: ferr | ~maj, parity: perr, data: data};
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, sp, v0, v1} <= '1;
      period_q <= RST_PERIOD;
      state <= S_IDLE;
      cnt <= '0;
      per <= RST_PERIOD;
      idx <= '0;
      db <= '0;
      par <= PAR_NONE;
      st2 <= 1'b0;
      data <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      {s1, s2, sp} <= {uart_rxd, s1, s2};
      v0 <= (cnt == half - 16'd1) ? s2 : v0;
      v1 <= (cnt == half) ? s2 : v1;
      period_q <= wr_bit_period_i ? clamp_period(bit_period_i) : period_q;
      state <= state_n;
      cnt <= cnt_n;
      per <= per_n;
      idx <= idx_n;
      db <= db_n;
      par <= par_n;
      st2 <= st2_n;
      data <= data_n;
      perr <= perr_n;
      ferr <= ferr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = bit_end ? '0 : cnt + 16'd1;
    per_n = per;
    idx_n = idx;
    db_n = db;
    par_n = par;
    st2_n = st2;
    data_n = data;
    perr_n = perr;
    ferr_n = ferr;
    push = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (uart_rx_en && fall) begin
          state_n = S_START;
          per_n = period_q;
          db_n = cfg_data_bits_i;
          par_n = parity_e'(cfg_parity_i);
          st2_n = cfg_stop2_i;
          data_n = '0;
          perr_n = 1'b0;
          ferr_n = 1'b0;
          idx_n = '0;
        end
      end
      S_START: state_n = (smp && maj) ? S_IDLE : bit_end ? S_DATA : S_START;
      S_DATA: begin
        if (smp) data_n[idx] = maj;
        if (bit_end) begin
          idx_n = (idx == {1'b1, db}) ? 3'd0 : idx + 3'd1;
          if (idx == {1'b1, db})
            state_n = (par == PAR_EVEN || par == PAR_ODD) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (smp) perr_n = (par == PAR_EVEN) ? (^data ^ maj) : ~(^data ^ maj);
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (smp) ferr_n = ferr | ~maj;
        if (smp && idx[0] == st2) begin
          push = 1'b1;
          state_n = S_IDLE;
        end else if (bit_end) idx_n = 3'd1;
      end
      default: state_n = S_IDLE;
    endcase
    if (!uart_rx_en && state != S_IDLE) begin
      state_n = S_IDLE;
      push = 1'b0;
    end
  end
  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data(wr_entry),
    .rd_en(rd_en_i),
    .rd_data(head),
    .valid(rd_valid_o),
    .count(fifo_count_o),
    .drop(drop)
  );
  assign rd_data_o = head.data;
  assign rd_parity_err_o = head.parity;
  assign rd_frame_err_o = head.frame;
  always_ff @(posedge clk) begin
    if (rst) overrun_o <= 1'b0;
    else overrun_o <= drop ? 1'b1 : clr_overrun_i ? 1'b0 : overrun_o;
  end
endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, reset baud rate; reset bit period = CLK_FREQ/BAUD_RATE (integer division).
REQ-003 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, >= 2.
REQ-004 clk  in  1  single clock; every register of the block is clocked on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 wr_bit_period_i  in  1  load bit_period_i into the bit-period register.
REQ-007 bit_period_i  in  16  clocks per bit; values below 4 are stored as 4.
REQ-008 cfg_data_bits_i  in  2  data bits per frame: 0->5, 1->6, 2->7, 3->8.
REQ-009 cfg_parity_i  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-010 cfg_stop2_i  in  1  1 = two stop bits, 0 = one stop bit.
REQ-011 uart_rx_en  in  1  receiver enable.
REQ-012 uart_rxd  in  1  asynchronous serial line; idle level is 1.
REQ-013 rd_en_i  in  1  pop the FIFO head.
REQ-014 rd_valid_o  out  1  FIFO not empty.
REQ-015 rd_data_o  out  8  FIFO head data, zero-extended above cfg data width; first-word fall-through.
REQ-016 rd_parity_err_o  out  1  parity error flag stored with the head byte.
REQ-017 rd_frame_err_o  out  1  framing error flag stored with the head byte.
REQ-018 fifo_count_o  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
REQ-019 overrun_o  out  1  sticky: a byte was dropped because the FIFO was full.
REQ-020 clr_overrun_i  in  1  clears overrun_o.

Function
REQ-021 uart_rxd passes through a 2-flop synchroniser; both flops load 1 on reset.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE -> START on a synchronised falling edge while uart_rx_en=1; the bit-period counter starts at the same moment.
REQ-024 Each bit is sampled at count bit_period/2; the sample is the majority of the synchronised line at counts half-1, half and half+1.
REQ-025 START: a sampled 1 is a false start and returns the FSM to IDLE; no push and no flag.
REQ-026 DATA: bits are shifted in LSB first, for cfg data-width bits; then PARITY if parity is enabled, else STOP.
REQ-027 PARITY: error when even mode and the XOR of data and parity bit is 1, or odd mode and it is 0.
REQ-028 STOP: any stop bit sampled 0 sets the frame flag.
REQ-029 STOP: with cfg_stop2_i=1 the second stop bit is also sampled.
REQ-030 Push {frame, parity, data} at the sample point of the last stop bit; FSM -> IDLE in the same cycle; rd_valid_o rises the next cycle.
REQ-031 Config inputs and the bit-period register are latched at START entry; changes mid-frame do not affect the current frame.
REQ-032 uart_rx_en=0 mid-frame: FSM -> IDLE next cycle; the partial frame is discarded with no push.
REQ-033 Push while full: byte dropped, overrun_o=1 next cycle.
REQ-034 Push while full with rd_en_i=1 in the same cycle: pop and push both occur; no overrun.
REQ-035 rd_en_i while empty is ignored; pointers wrap modulo FIFO_DEPTH.
REQ-036 clr_overrun_i and an overrun event in the same cycle: overrun_o stays 1.

Reset
REQ-037 On rst: FSM=IDLE, FIFO empty, rd_valid_o=0, rd_data_o=0, rd_parity_err_o=0, rd_frame_err_o=0, fifo_count_o=0, overrun_o=0, bit-period register=CLK_FREQ/BAUD_RATE.
REQ-038 rst mid-frame aborts the frame; no push.

Structure
REQ-039 Package uart_pkg holds the parity-mode enum, the FSM state enum and the FIFO-entry struct {frame, parity, data[7:0]}.
REQ-040 The FIFO is the sub-module sync_fifo, parametrised by width and depth, with first-word fall-through.

Verification
REQ-041 Bit period 16, 8N1, send 0xA5 -> one entry 0xA5, both flags 0, rd_valid_o rises 1 cycle after the last stop-bit sample.
REQ-042 Bit period 16, 7O2, send 0x3C with a wrong parity bit -> data 0x3C, rd_parity_err_o=1; then 0x3C with a second stop bit of 0 -> rd_frame_err_o=1.
REQ-043 Line low for 5 clocks then high (bit period 16) -> no entry, FSM back in IDLE.
REQ-044 FIFO_DEPTH=4, send 5 bytes 0x01..0x05 with no reads -> entries 0x01..0x04, overrun_o=1; clr_overrun_i -> 0.
REQ-045 FIFO full, rd_en_i asserted in the push cycle of 0x05 -> count stays 4, overrun_o=0, head becomes 0x02.
REQ-046 Deassert uart_rx_en in the middle of data bit 3 -> no push; a following 0x5A is received correctly.
